n_result_reader: RTL

Read-back engine for the NPU result RAM on the AXI side. It accepts a burst read request (start address and length) and issues single-cycle synchronous reads to the result RAM. Returned words are buffered in a small FIFO and streamed out on a valid/ready port, while a running signed argmax is computed over the burst. It sits beside the RAM write selector and only touches the RAM while the AXI side owns it.

---
 rtl/n_result_reader_pkg.sv | 28 ++
 rtl/n_rslt_fifo.sv | 81 ++++++++
 rtl/n_result_reader.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/n_result_reader_pkg.sv
// ---------------------------------------------------------------------------
// n_result_reader_pkg
// Shared definitions for the NPU result RAM read-back engine.
//   SEL_NPU_ALU : value of npu_alu_sel_i meaning the NPU ALU owns the RAM
//   RESULT_STA/RESULT_END : bit range of a result word, giving RESULT_W
//   state_e     : read engine FSM states (IDLE / READ / DRAIN)
// ---------------------------------------------------------------------------
`ifndef N_RESULT_READER_DEFS
`define N_RESULT_READER_DEFS
`define Sel_NPU_ALU 1'b1
`define RESULT_STA  0
`define RESULT_END  31
`endif

package n_result_reader_pkg;

    localparam logic SEL_NPU_ALU = `Sel_NPU_ALU;
    localparam int   RESULT_STA  = `RESULT_STA;
    localparam int   RESULT_END  = `RESULT_END;
    localparam int   RESULT_W    = RESULT_END - RESULT_STA + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/n_rslt_fifo.sv
// ---------------------------------------------------------------------------
// n_rslt_fifo
// Small synchronous FIFO holding returned result words with their tags.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i        : write push_data_i this cycle
//   push_data_i   : entry to store ({last, idx, data} in the reader)
//   pop_i         : discard the head entry this cycle (ignored when empty)
//   head_o        : current head entry
//   count_o       : number of stored entries
// A push and a pop in the same cycle are both honoured, even when full.
// ---------------------------------------------------------------------------
module n_rslt_fifo #(
    parameter  int WIDTH = 41,
    parameter  int DEPTH = 3,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop_i && (count_q != '0);
        do_push  = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

        if (do_push) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/n_result_reader.sv
// ---------------------------------------------------------------------------
// n_result_reader
// Burst read-back engine for the NPU result RAM (AXI side).
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   npu_alu_sel_i          : RAM owner; reads only issue when not SEL_NPU_ALU
//   req_valid_i/ready_o    : burst request handshake (ready only in IDLE)
//   req_addr_i, req_len_i  : start address and beats-minus-one
//   ram_en_r_o/r_addr_o    : single-cycle synchronous RAM read port
//   ram_r_data_i           : read data, valid the cycle after ram_en_r_o
//   rd_valid_o/ready_i     : output beat stream, rd_data_o / rd_last_o
//   busy_o                 : engine is not IDLE
//   max_valid_o/idx/val    : signed argmax over the burst
// ---------------------------------------------------------------------------
module n_result_reader
    import n_result_reader_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = RESULT_W,
    parameter int FIFO_DEPTH = 3
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              npu_alu_sel_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [7:0]        req_len_i,
    output logic              ram_en_r_o,
    output logic [ADDR_W-1:0] ram_r_addr_o,
    input  logic [DATA_W-1:0] ram_r_data_i,
    output logic              rd_valid_o,
    input  logic              rd_ready_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_last_o,
    output logic              busy_o,
    output logic              max_valid_o,
    output logic [7:0]        max_idx_o,
    output logic [DATA_W-1:0] max_val_o
);

    localparam int ENTRY_W = DATA_W + 9;
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        issue_idx_q, issue_idx_d;
    logic              inflight_q, inflight_d;
    logic [7:0]        inflight_idx_q, inflight_idx_d;
    logic              inflight_last_q, inflight_last_d;
    logic              max_valid_q, max_valid_d;
    logic [7:0]        max_idx_q, max_idx_d;
    logic [DATA_W-1:0] max_val_q, max_val_d;

    logic [ENTRY_W-1:0] fifo_head;
    logic [CNT_W-1:0]   fifo_count;
    logic               head_last;
    logic [7:0]         head_idx;
    logic [DATA_W-1:0]  head_data;
    logic               pop;
    logic               last_pop;
    logic [CNT_W:0]     occupancy;
    logic               credit_ok;
    logic               owned;
    logic               issue;

    // A read may only issue if the FIFO is guaranteed room for it once
    // it returns, counting the word already on its way back.
    assign occupancy = {1'b0, fifo_count} + (CNT_W + 1)'(inflight_q);
    assign credit_ok = occupancy < (CNT_W + 1)'(FIFO_DEPTH);
    assign owned     = (npu_alu_sel_i != SEL_NPU_ALU);

    assign {head_last, head_idx, head_data} = fifo_head;
    assign pop      = rd_valid_o && rd_ready_i;
    assign last_pop = pop && (head_idx == len_q);

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        len_d           = len_q;
        issue_idx_d     = issue_idx_q;
        inflight_d      = 1'b0;
        inflight_idx_d  = inflight_idx_q;
        inflight_last_d = inflight_last_q;
        max_valid_d     = max_valid_q;
        max_idx_d       = max_idx_q;
        max_val_d       = max_val_q;
        issue           = 1'b0;
        req_ready_o     = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    addr_d      = req_addr_i;
                    len_d       = req_len_i;
                    issue_idx_d = '0;
                    max_valid_d = 1'b0;
                    max_idx_d   = '0;
                    max_val_d   = '0;
                    state_d     = READ;
                end
            end
            READ: begin
                if (owned && credit_ok) begin
                    issue           = 1'b1;
                    inflight_d      = 1'b1;
                    inflight_idx_d  = issue_idx_q;
                    inflight_last_d = (issue_idx_q == len_q);
                    addr_d          = addr_q + 1'b1;
                    issue_idx_d     = issue_idx_q + 1'b1;
                    if (issue_idx_q == len_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (last_pop) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Argmax follows the push side; the first beat seeds it and later
        // beats must be strictly greater, so ties keep the lower index.
        if (inflight_q) begin
            if ((inflight_idx_q == 8'd0) ||
                ($signed(ram_r_data_i) > $signed(max_val_q))) begin
                max_idx_d = inflight_idx_q;
                max_val_d = ram_r_data_i;
            end
        end

        if (last_pop) begin
            max_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            len_q           <= '0;
            issue_idx_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_idx_q  <= '0;
            inflight_last_q <= 1'b0;
            max_valid_q     <= 1'b0;
            max_idx_q       <= '0;
            max_val_q       <= '0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            len_q           <= len_d;
            issue_idx_q     <= issue_idx_d;
            inflight_q      <= inflight_d;
            inflight_idx_q  <= inflight_idx_d;
            inflight_last_q <= inflight_last_d;
            max_valid_q     <= max_valid_d;
            max_idx_q       <= max_idx_d;
            max_val_q       <= max_val_d;
        end
    end

    n_rslt_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (inflight_q),
        .push_data_i ({inflight_last_q, inflight_idx_q, ram_r_data_i}),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count)
    );

    assign ram_en_r_o   = issue;
    assign ram_r_addr_o = addr_q;
    assign rd_valid_o   = (fifo_count != '0);
    assign rd_data_o    = head_data;
    assign rd_last_o    = rd_valid_o && head_last;
    assign busy_o       = (state_q != IDLE);
    assign max_valid_o  = max_valid_q;
    assign max_idx_o    = max_idx_q;
    assign max_val_o    = max_val_q;

endmodule
